// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, FSM encoding, buffer entry type and PC-next helper for the fetch controller.
package fetch_ctrl_pkg;

  localparam int unsigned PC_WIDTH   = 32;
  localparam int unsigned WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_HOLD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [WORD_WIDTH-1:0] insn;
    logic                  pred;
  } fetch_entry_t;

  // Sequential increment wraps naturally modulo 2^PC_WIDTH.
  function automatic logic [PC_WIDTH-1:0] pc_next(
    input logic [PC_WIDTH-1:0] pc,
    input logic                taken,
    input logic [PC_WIDTH-1:0] target,
    input int unsigned         inc
  );
    return taken ? target : pc + PC_WIDTH'(inc);
  endfunction

endpackage

// File: rtl/fetch_ctrl_buf.sv
// One-entry holding register for the word presented to the IF pipeline register.
module fetch_ctrl_buf
  import fetch_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  fetch_entry_t load_entry,
  input  logic         consume,
  input  logic         clear,
  output logic         valid,
  output fetch_entry_t entry
);

  // Clear beats load (redirect discards same-cycle data); load beats consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      entry <= load_entry;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: owns fetch PC, single-outstanding imem requests, redirect/drop handling.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned         PC_INC   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_en,
  input  logic                  id_stall,
  input  logic                  ex_redirect,
  input  logic [PC_WIDTH-1:0]   ex_redirect_pc,
  input  logic                  bp_taken,
  input  logic [PC_WIDTH-1:0]   bp_target,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [WORD_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [WORD_WIDTH-1:0] insn,
  output logic                  predt_br_taken,
  output logic                  if_stall,
  output logic                  if_flush
);

  fetch_state_t          state, state_next;
  logic                  drop, drop_next;
  logic [PC_WIDTH-1:0]   fetch_pc;
  logic [PC_WIDTH-1:0]   req_pc;
  logic                  req_pred;
  logic                  req_live;

  logic                  buf_valid;
  fetch_entry_t          buf_entry;
  fetch_entry_t          load_entry;
  logic                  buf_load;
  logic                  buf_clear;
  logic                  consume;
  logic                  granted;

  assign consume = buf_valid & ~id_stall & cpu_en;
  assign granted = imem_req & imem_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH_IDLE;
      drop  <= 1'b0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
    end
  end

  always_comb begin
    state_next = state;
    drop_next  = drop;
    if (ex_redirect) begin
      case (state)
        FETCH_WAIT: begin
          if (imem_rvalid) begin
            state_next = FETCH_REQ;
            drop_next  = 1'b0;
          end else begin
            drop_next  = 1'b1;
          end
        end
        FETCH_REQ: begin
          if (granted) begin
            state_next = FETCH_WAIT;
            drop_next  = 1'b1;
          end
        end
        default: state_next = FETCH_REQ;
      endcase
    end else begin
      case (state)
        FETCH_IDLE: if (cpu_en) state_next = FETCH_REQ;
        FETCH_REQ: begin
          if (granted) begin
            state_next = FETCH_WAIT;
            drop_next  = 1'b0;
          end
        end
        FETCH_WAIT: begin
          if (imem_rvalid) begin
            drop_next  = 1'b0;
            state_next = (drop | (cpu_en & ~id_stall)) ? FETCH_REQ : FETCH_HOLD;
          end
        end
        FETCH_HOLD: if (consume) state_next = FETCH_REQ;
        default:    state_next = FETCH_IDLE;
      endcase
    end
  end

  // A new request only starts when its response is guaranteed a free buffer slot;
  // once presented it stays up until granted, even if cpu_en drops.
  always_comb begin
    imem_req   = (state == FETCH_REQ) & (req_live | (cpu_en & (~buf_valid | consume)));
    imem_addr  = fetch_pc;
    buf_load   = (state == FETCH_WAIT) & imem_rvalid & ~drop & ~ex_redirect;
    buf_clear  = ex_redirect;
    load_entry = '{pc: req_pc, insn: imem_rdata, pred: req_pred};
    if_stall   = ~buf_valid | id_stall | ~cpu_en;
    if_flush   = ex_redirect;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      req_pred <= 1'b0;
      req_live <= 1'b0;
    end else begin
      req_live <= imem_req & ~imem_gnt & ~ex_redirect;
      if (ex_redirect) begin
        fetch_pc <= ex_redirect_pc;
      end else if (granted) begin
        fetch_pc <= pc_next(fetch_pc, bp_taken, bp_target, PC_INC);
      end
      if (granted) begin
        req_pc   <= fetch_pc;
        req_pred <= bp_taken;
      end
    end
  end

  fetch_ctrl_buf u_fetch_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (buf_load),
    .load_entry (load_entry),
    .consume    (consume),
    .clear      (buf_clear),
    .valid      (buf_valid),
    .entry      (buf_entry)
  );

  assign pc             = buf_entry.pc;
  assign insn           = buf_entry.insn;
  assign predt_br_taken = buf_entry.pred;

endmodule
